mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 116 +++++++++++
 tb/tb_mdu_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MIPS-style HI/LO multiply/divide unit with multi-cycle MUL and restoring DIV.
// Define MDU_DIV0_TRAP_EN to short-circuit divide-by-zero with a div0 pulse instead of iterating.
module mdu_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} state_t;
    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a, r_b, r_rem, r_quo, r_hi, r_lo;
    logic        r_sgn, r_neg_q, r_neg_r, r_done;
    logic        w_acc, w_is_mul, w_is_div, w_sgn, w_bz, w_trap;
    logic [63:0] w_prod;
    logic [33:0] w_trial;

    assign w_acc    = start && (r_state == IDLE);
    assign w_is_mul = (op[2:1] == 2'b00);
    assign w_is_div = (op[2:1] == 2'b01);
    assign w_sgn    = !op[0];
    assign w_bz     = (b == 32'd0);
    // Sign-extend to 64 bits so a plain multiply yields the correct signed or unsigned product.
    assign w_prod   = {{32{r_sgn & r_a[31]}}, r_a} * {{32{r_sgn & r_b[31]}}, r_b};
    assign w_trial  = {1'b0, r_rem, r_quo[31]} - {2'b00, r_b};

`ifdef MDU_DIV0_TRAP_EN
    logic r_div0;
    assign w_trap = w_acc && w_is_div && w_bz;
    assign div0   = r_div0;
    always_ff @(posedge clk)
        r_div0 <= rst ? 1'b0 : w_trap;
`else
    assign w_trap = 1'b0;
    assign div0   = 1'b0;
`endif

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !w_acc ? IDLE : w_is_mul ? MUL : (w_is_div && !w_trap) ? DIV : IDLE;
            MUL:     w_next = (r_cnt == 5'd0) ? IDLE : MUL;
            DIV:     w_next = (r_cnt == 5'd0) ? SIGN : DIV;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc && (w_is_mul || w_is_div)) begin
                        r_cnt   <= w_is_mul ? 5'(MUL_LAT - 1) : 5'd31;
                        r_a     <= a;
                        r_b     <= (w_is_div && w_sgn && b[31]) ? -b : b;
                        r_quo   <= (w_sgn && a[31]) ? -a : a;
                        r_rem   <= 32'd0;
                        r_sgn   <= w_sgn;
                        r_neg_q <= w_sgn && (a[31] ^ b[31]) && !w_bz;
                        r_neg_r <= w_sgn && a[31];
                        r_done  <= w_trap;
                    end
                    if (w_acc && op == 3'b100) r_hi <= a;
                    if (w_acc && op == 3'b101) r_lo <= a;
                end
                MUL: begin
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        {r_hi, r_lo} <= w_prod;
                        r_done       <= 1'b1;
                    end
                end
                DIV: begin
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                    r_rem <= w_trial[33] ? {r_rem[30:0], r_quo[31]} : w_trial[31:0];
                    r_quo <= {r_quo[30:0], !w_trial[33]};
                end
                default: begin
                    r_lo   <= r_neg_q ? -r_quo : r_quo;
                    r_hi   <= r_neg_r ? -r_rem : r_rem;
                    r_done <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (MUL_LAT = 4).
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, div0;
    logic [31:0] hi, lo;
    int          n_checks = 0;
    int          n_errors = 0;

    mdu_ctrl #(.MUL_LAT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Issue an op, then wait (bounded) for done; optionally fire an MTHI while busy at cycle inj.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input int lat, input int nbusy, input int inj);
        int n = 0;
        int nb = 0;
        issue(o, av, bv);
        while (!done && n < 60) begin
            nb += int'(busy);
            start = (n == inj);
            if (n == inj) begin
                op = 3'b100; a = 32'hDEADBEEF;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_busycyc"}, 32'(nb), 32'(nbusy));
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div0", {31'd0, div0}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        run("mult", 3'b000, 32'hFFFFFFFE, 32'h00000003, 4, 4, -1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        @(posedge clk); #1;
        chk("mult_done_1cyc", {31'd0, done}, 32'd0);
        chk("mult_hi_hold", hi, 32'hFFFFFFFF);

        run("multu", 3'b001, 32'hFFFFFFFE, 32'h00000003, 4, 4, -1);
        chk("multu_hi", hi, 32'h00000002);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        run("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'h00000002, 33, 33, -1);
        chk("div_m7_2_lo", lo, 32'hFFFFFFFD);
        chk("div_m7_2_hi", hi, 32'hFFFFFFFF);
        run("divu_back2back", 3'b011, 32'h80000000, 32'hFFFFFFFF, 33, 33, -1);
        chk("divu_lo", lo, 32'h00000000);
        chk("divu_hi", hi, 32'h80000000);

        run("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 33, 33, 10);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h00000000);
        chk("div_ovf_div0", {31'd0, div0}, 32'd0);

        issue(3'b100, 32'h11111111, 32'd0);
        chk("mthi_hi", hi, 32'h11111111);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_done", {31'd0, done}, 32'd0);
        issue(3'b101, 32'h22222222, 32'd0);
        chk("mtlo_lo", lo, 32'h22222222);
        chk("mtlo_hi", hi, 32'h11111111);

        issue(3'b110, 32'h33333333, 32'h44444444);
        chk("nop_hi", hi, 32'h11111111);
        chk("nop_lo", lo, 32'h22222222);
        chk("nop_busy", {31'd0, busy}, 32'd0);
        chk("nop_done", {31'd0, done}, 32'd0);

`ifdef MDU_DIV0_TRAP_EN
        run("divu_z", 3'b011, 32'h12345678, 32'd0, 0, 0, -1);
        chk("divu_z_div0", {31'd0, div0}, 32'd1);
        chk("divu_z_hi", hi, 32'h11111111);
        chk("divu_z_lo", lo, 32'h22222222);
        @(posedge clk); #1;
        chk("divu_z_div0_clr", {31'd0, div0}, 32'd0);
`else
        run("divu_z", 3'b011, 32'h12345678, 32'd0, 33, 33, -1);
        chk("divu_z_div0", {31'd0, div0}, 32'd0);
        chk("divu_z_hi", hi, 32'h12345678);
        chk("divu_z_lo", lo, 32'hFFFFFFFF);
        run("div_z", 3'b010, 32'hFFFFFFF9, 32'd0, 33, 33, -1);
        chk("div_z_hi", hi, 32'hFFFFFFF9);
        chk("div_z_lo", lo, 32'hFFFFFFFF);
`endif

        issue(3'b010, 32'h00001234, 32'h00000007);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        seen = 0;
        repeat (40) begin
            seen += int'(done);
            @(posedge clk); #1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        issue(3'b101, 32'hA5A5A5A5, 32'd0);
        chk("abort_mtlo", lo, 32'hA5A5A5A5);

        rst = 1'b1;
        issue(3'b100, 32'h55555555, 32'd0);
        rst = 1'b0;
        chk("rst_prio_hi", hi, 32'd0);
        chk("rst_prio_lo", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
